// File: rtl/sfx_pkg.sv
// Shared types and the saturation helper for the sound-effect mixer.
package sfx_pkg;

  typedef enum logic [1:0] {M_WAIT, M_READ, M_SUM, M_WRITE} mix_state_t;
  typedef enum logic {CH_IDLE, CH_PLAY} ch_state_t;

  localparam int SAT_W = 64;

  // Clamp a wide signed value into the signed range of a w-bit sample.
  function automatic logic signed [SAT_W-1:0] sat_to_sample(
    input logic signed [SAT_W-1:0] v,
    input int unsigned             w
  );
    logic signed [SAT_W-1:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/sfx_mixer_if.sv
// Codec write port: ready from the codec FIFO, stereo write strobe and data from the mixer.
interface sfx_mixer_if #(parameter int OUT_W = 32);
  logic             write_ready;
  logic             write;
  logic [OUT_W-1:0] writedata_left;
  logic [OUT_W-1:0] writedata_right;

  modport master (input write_ready, output write, writedata_left, writedata_right);
  modport slave  (output write_ready, input write, writedata_left, writedata_right);
endinterface

// File: rtl/sfx_channel.sv
// One effect channel: start-request latch, idle/play FSM and ROM address counter.
module sfx_channel
  import sfx_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_trig,
  input  logic              i_consume,
  input  logic              i_advance,
  input  logic [ADDR_W-1:0] i_len,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_busy
);

  ch_state_t         r_state, w_state_nx;
  logic [ADDR_W-1:0] r_addr, w_addr_nx;
  logic              r_pend, w_pend_nx, w_start;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= CH_IDLE;
      r_addr  <= '0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_addr  <= w_addr_nx;
      r_pend  <= w_pend_nx;
    end
  end

  // A trig landing on a consume cycle folds into the same start.
  always_comb begin
    w_start    = i_consume & (r_pend | i_trig);
    w_pend_nx  = i_consume ? 1'b0 : (r_pend | i_trig);
    w_state_nx = r_state;
    w_addr_nx  = r_addr;
    if (w_start) begin
      w_addr_nx  = '0;
      w_state_nx = (i_len == '0) ? CH_IDLE : CH_PLAY;
    end else if (i_advance && r_state == CH_PLAY) begin
      if (r_addr == i_len - ADDR_W'(1)) begin
        w_state_nx = CH_IDLE;
        w_addr_nx  = '0;
      end else begin
        w_addr_nx = r_addr + ADDR_W'(1);
      end
    end
  end

  assign o_addr = r_addr;
  assign o_busy = (r_state == CH_PLAY);

endmodule

// File: rtl/sfx_mixer.sv
// Multi-channel effect player: frame FSM, saturating mix and codec write port.
// Define SFX_MIXER_GAIN_EN to add a per-channel 0..3 arithmetic right-shift (i_ch_shift).
module sfx_mixer
  import sfx_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 16,
  parameter int ADDR_W   = 12,
  parameter int OUT_W    = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CH-1:0]                i_trig,
  input  logic [NUM_CH-1:0][ADDR_W-1:0]    i_ch_len,
`ifdef SFX_MIXER_GAIN_EN
  input  logic [NUM_CH-1:0][1:0]           i_ch_shift,
`endif
  output logic [NUM_CH-1:0][ADDR_W-1:0]    o_rom_addr,
  input  logic [NUM_CH-1:0][SAMPLE_W-1:0]  i_rom_q,
  output logic [NUM_CH-1:0]                o_busy,
  sfx_mixer_if.master                      cw
);

  localparam int SUM_W = SAMPLE_W + $clog2(NUM_CH) + 1;

  mix_state_t                r_mst, w_mst_nx;
  logic [OUT_W-1:0]          r_data;
  logic                      w_consume, w_advance;
  logic signed [SAMPLE_W-1:0] w_smp;
  logic signed [SUM_W-1:0]   w_sum;
  logic signed [SAT_W-1:0]   w_sat;
  logic [OUT_W-1:0]          w_word;

  assign w_consume = (r_mst == M_WAIT) || (r_mst == M_WRITE);
  assign w_advance = (r_mst == M_WRITE);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    sfx_channel #(.ADDR_W(ADDR_W)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .i_trig    (i_trig[c]),
      .i_consume (w_consume),
      .i_advance (w_advance),
      .i_len     (i_ch_len[c]),
      .o_addr    (o_rom_addr[c]),
      .o_busy    (o_busy[c])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) r_mst <= M_WAIT;
    else      r_mst <= w_mst_nx;
  end

  always_comb begin
    w_mst_nx = r_mst;
    case (r_mst)
      M_WAIT:  if (cw.write_ready) w_mst_nx = M_READ;
      M_READ:  w_mst_nx = M_SUM;
      M_SUM:   w_mst_nx = M_WRITE;
      M_WRITE: w_mst_nx = M_WAIT;
      default: w_mst_nx = M_WAIT;
    endcase
  end

  // Channel state cannot change between M_READ and M_SUM, so busy gates rom_q safely here.
  always_comb begin
    w_sum = '0;
    w_smp = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_smp = $signed(i_rom_q[c]);
`ifdef SFX_MIXER_GAIN_EN
      w_smp = w_smp >>> i_ch_shift[c];
`endif
      if (o_busy[c]) w_sum = w_sum + SUM_W'(w_smp);
    end
  end

  assign w_sat  = sat_to_sample(SAT_W'(w_sum), SAMPLE_W);
  assign w_word = OUT_W'(w_sat << (OUT_W - SAMPLE_W));

  always_ff @(posedge clk) begin
    if (!rst)                r_data <= '0;
    else if (r_mst == M_SUM) r_data <= w_word;
  end

  assign cw.write           = (r_mst == M_WRITE);
  assign cw.writedata_left  = r_data;
  assign cw.writedata_right = r_data;

endmodule

// File: doc/sfx_mixer.md
# sfx_mixer

Parametrised multi-channel sound-effect player and mixer for the game audio path. Each channel plays a fixed-length signed sample clip from an external synchronous ROM when triggered by a game event. Active channels are summed with saturation, and one stereo frame is delivered to the audio codec write port each time the codec reports room.

## Interface
- NUM_CH, 4: number of independent effect channels (1..8).
- SAMPLE_W, 16: signed ROM sample width.
- ADDR_W, 12: ROM address and clip-length width per channel.
- OUT_W, 32: codec write word width; must be ≥ SAMPLE_W.
- clk  in  1  system clock (50 MHz).
- rst  in  1  reset, synchronous, active-low.
- trig  in  NUM_CH  start request per channel; each high cycle counts as one request.
- ch_len  in  NUM_CH*ADDR_W  clip length in samples per channel; static while that channel plays.
- rom_addr  out  NUM_CH*ADDR_W  per-channel ROM address.
- rom_q  in  NUM_CH*SAMPLE_W  per-channel ROM data; 1-cycle latency.
- write_ready  in  1  codec output FIFO has room.
- write  out  1  one-cycle write strobe to codec.
- writedata_left  out  OUT_W  mixed sample, left.
- writedata_right  out  OUT_W  mixed sample, right; always equal to left.
- busy  out  NUM_CH  channel is playing.

## Operation
- Channel FSM states:
  - CH_IDLE → CH_PLAY on a start; addr←0.
  - A start request is held in a per-channel pending bit.
  - Pending is consumed in any M_WAIT or M_WRITE cycle.
  - A trig arriving in the same cycle as consumption merges into that single start.
- ch_len = 0: start consumed and ignored; channel stays CH_IDLE.
- Retrigger while in CH_PLAY restarts at addr 0. A start takes priority over the M_WRITE advance.
- M_WRITE advance, CH_PLAY channels only:
  - addr == ch_len−1 → CH_IDLE, addr←0.
  - Otherwise addr+1.
- Mix FSM:
  - M_WAIT → M_READ when write_ready=1.
  - M_READ → M_SUM. Addresses stable; ROM latches.
  - M_SUM → M_WRITE. Register the mix.
  - M_WRITE → M_WAIT. write=1.
- Mix arithmetic:
  - Sum rom_q of CH_PLAY channels in SAMPLE_W+$clog2(NUM_CH)+1 signed bits. Idle channels contribute 0.
  - Saturate the sum to the signed SAMPLE_W range.
  - Place the result in the OUT_W MSBs with low bits zero.
- Reset (rst=0 at a clk edge, including mid-frame):
  - Outputs: write=0, writedata_*=0, busy=0, rom_addr=0.
  - Internal: pending cleared, all FSMs to idle/M_WAIT.
  - Any partially built frame is dropped.

## Timing
- write_ready sampled high in M_WAIT at cycle 0 → write=1 in cycle 3 with valid writedata.
- Minimum frame period: 4 cycles.
- write is high for exactly one cycle per frame.
- writedata_* hold their value until the next M_WRITE.
- write_ready low: FSM stays in M_WAIT; no address advances; busy unchanged.
- write_ready is ignored outside M_WAIT.
- busy falls in the cycle after the M_WRITE that plays the last sample.
- A trig in cycle n is visible on busy in cycle n+1 at the earliest (next M_WAIT/M_WRITE cycle).
- rom_q in cycle n+1 corresponds to rom_addr in cycle n. Only rom_q during M_SUM is used.

## Configuration
- SFX_MIXER_GAIN_EN defined:
  - Adds input ch_shift, NUM_CH*2 bits.
  - Each playing sample is arithmetically right-shifted by 0..3 before summation.
- SFX_MIXER_GAIN_EN undefined:
  - The ch_shift port is absent.
  - Samples are summed unscaled.

## Structure
- Package sfx_pkg holds:
  - mix_state_t (M_WAIT, M_READ, M_SUM, M_WRITE).
  - ch_state_t (CH_IDLE, CH_PLAY).
  - Saturation function sat_to_sample.
- Sub-module sfx_channel: pending bit, ch_state_t FSM and address counter; instantiated NUM_CH times via generate.
- Mixer FSM, adder tree and output registers live in sfx_mixer.

## Test plan
All scenarios use NUM_CH=4, SAMPLE_W=16, OUT_W=32.
- Reset: drive rst=0 mid-frame with busy=4'b0011 → next cycle write=0, writedata_*=0, busy=0, rom_addr=0.
- Single clip: ch_len[0]=3, ROM0={0x0100,0x0200,0x0300}, trig[0] pulse, write_ready=1 → writes 0x01000000, 0x02000000, 0x03000000, then 0x00000000; busy[0] falls after the third write.
- Saturation, positive: ch0 and ch1 each 0x7000 → 0x7FFF0000.
- Saturation, negative: both channels 0x9000 → 0x80000000.
- Retrigger: ch_len[0]=5, trig[0] again after 2 writes → rom_addr[0] returns to 0; 5 further samples play; busy[0] stays high.
- Backpressure: write_ready=0 for 10 cycles while playing → no write, rom_addr unchanged; resumes with write 3 cycles after write_ready=1.
- Gain (SFX_MIXER_GAIN_EN): ch_shift[0]=2, sample 0x0400 → 0x01000000; ch_len=0 with trig → busy stays 0.
